// File: rtl/decode_stage.sv
// RV32/RV64 IM decode stage: combinational decode feeding a two-entry (main + skid)
// output buffer so that in_ready is driven from a flop.

package decode_stage_pkg;
  localparam int unsigned CX_W  = 6;
  localparam int unsigned ALU_W = 11;
  localparam int unsigned MD_W  = 8;
  localparam int unsigned LS_W  = 4;

  localparam int unsigned CX_BEQ  = 0;
  localparam int unsigned CX_BNE  = 1;
  localparam int unsigned CX_BLT  = 2;
  localparam int unsigned CX_BGE  = 3;
  localparam int unsigned CX_JAL  = 4;
  localparam int unsigned CX_JALR = 5;

  localparam int unsigned ALU_ADD   = 0;
  localparam int unsigned ALU_SUB   = 1;
  localparam int unsigned ALU_SLL   = 2;
  localparam int unsigned ALU_SLT   = 3;
  localparam int unsigned ALU_XOR   = 4;
  localparam int unsigned ALU_SRL   = 5;
  localparam int unsigned ALU_SRA   = 6;
  localparam int unsigned ALU_OR    = 7;
  localparam int unsigned ALU_AND   = 8;
  localparam int unsigned ALU_LUI   = 9;
  localparam int unsigned ALU_AUIPC = 10;

  localparam logic [LS_W-1:0] LS_B = 4'b0001;
  localparam logic [LS_W-1:0] LS_H = 4'b0010;
  localparam logic [LS_W-1:0] LS_W_ = 4'b0100;
  localparam logic [LS_W-1:0] LS_D = 4'b1000;
endpackage

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned PC_WIDTH = 48,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [31:0]         out_inst,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic [XLEN-1:0]     out_imm,
  output logic                out_src1_is_reg,
  output logic                out_src2_is_reg,
  output logic                out_need_to_wb,
  output logic [CX_W-1:0]     out_cx_type,
  output logic [ALU_W-1:0]    out_alu_type,
  output logic [MD_W-1:0]     out_muldiv_type,
  output logic                out_is_word,
  output logic                out_is_imm,
  output logic                out_is_load,
  output logic                out_is_store,
  output logic                out_is_unsigned,
  output logic [LS_W-1:0]     out_ls_size,
  output logic                out_illegal,
  output logic [CNT_W-1:0]    decode_count
);

  localparam bit RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         inst;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [XLEN-1:0]     imm;
    logic                src1_is_reg;
    logic                src2_is_reg;
    logic                need_to_wb;
    logic [CX_W-1:0]     cx;
    logic [ALU_W-1:0]    alu;
    logic [MD_W-1:0]     md;
    logic                is_word;
    logic                is_imm;
    logic                is_load;
    logic                is_store;
    logic                is_unsigned;
    logic [LS_W-1:0]     ls_size;
    logic                illegal;
  } uop_t;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'b0};
  assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  uop_t dec;
  logic bad;

  // Combinational decode of the offered instruction
  always_comb begin
    dec      = '0;
    bad      = 1'b0;
    dec.pc   = in_pc;
    dec.inst = in_inst;
    dec.rs1  = in_inst[19:15];
    dec.rs2  = in_inst[24:20];
    dec.rd   = in_inst[11:7];
    case (opcode)
      OPC_LOAD: begin
        dec.imm = sext(imm_i);
        dec.src1_is_reg = 1'b1;
        dec.need_to_wb = 1'b1;
        dec.is_load = 1'b1;
        dec.is_imm = 1'b1;
        dec.alu[ALU_ADD] = 1'b1;
        case (f3)
          3'b000: dec.ls_size = LS_B;
          3'b001: dec.ls_size = LS_H;
          3'b010: dec.ls_size = LS_W_;
          3'b011: begin dec.ls_size = LS_D; bad = !RV64; end
          3'b100: begin dec.ls_size = LS_B; dec.is_unsigned = 1'b1; end
          3'b101: begin dec.ls_size = LS_H; dec.is_unsigned = 1'b1; end
          3'b110: begin dec.ls_size = LS_W_; dec.is_unsigned = 1'b1; bad = !RV64; end
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.imm = sext(imm_s);
        dec.src1_is_reg = 1'b1;
        dec.src2_is_reg = 1'b1;
        dec.is_store = 1'b1;
        dec.is_imm = 1'b1;
        dec.alu[ALU_ADD] = 1'b1;
        case (f3)
          3'b000: dec.ls_size = LS_B;
          3'b001: dec.ls_size = LS_H;
          3'b010: dec.ls_size = LS_W_;
          3'b011: begin dec.ls_size = LS_D; bad = !RV64; end
          default: bad = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec.imm = sext(imm_i);
        dec.src1_is_reg = 1'b1;
        dec.need_to_wb = 1'b1;
        dec.is_imm = 1'b1;
        case (f3)
          3'b000: dec.alu[ALU_ADD] = 1'b1;
          3'b010: dec.alu[ALU_SLT] = 1'b1;
          3'b011: begin dec.alu[ALU_SLT] = 1'b1; dec.is_unsigned = 1'b1; end
          3'b100: dec.alu[ALU_XOR] = 1'b1;
          3'b110: dec.alu[ALU_OR] = 1'b1;
          3'b111: dec.alu[ALU_AND] = 1'b1;
          3'b001: begin
            dec.alu[ALU_SLL] = 1'b1;
            dec.imm = XLEN'(in_inst[25:20]);
            bad = (in_inst[31:26] != 6'd0) || (!RV64 && in_inst[25]);
          end
          default: begin
            dec.imm = XLEN'(in_inst[25:20]);
            if (in_inst[31:26] == 6'b000000) dec.alu[ALU_SRL] = 1'b1;
            else if (in_inst[31:26] == 6'b010000) dec.alu[ALU_SRA] = 1'b1;
            else bad = 1'b1;
            if (!RV64 && in_inst[25]) bad = 1'b1;
          end
        endcase
      end
      OPC_OP_IMM32: begin
        // shamt is 5 bits here, so f7 must match exactly (inst[25] included)
        dec.src1_is_reg = 1'b1;
        dec.need_to_wb = 1'b1;
        dec.is_imm = 1'b1;
        dec.is_word = 1'b1;
        dec.imm = XLEN'(in_inst[24:20]);
        bad = !RV64;
        case (f3)
          3'b000: begin dec.alu[ALU_ADD] = 1'b1; dec.imm = sext(imm_i); end
          3'b001: if (f7 == 7'b0000000) dec.alu[ALU_SLL] = 1'b1; else bad = 1'b1;
          3'b101: begin
            if (f7 == 7'b0000000) dec.alu[ALU_SRL] = 1'b1;
            else if (f7 == 7'b0100000) dec.alu[ALU_SRA] = 1'b1;
            else bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_OP: begin
        dec.src1_is_reg = 1'b1;
        dec.src2_is_reg = 1'b1;
        dec.need_to_wb = 1'b1;
        if (f7 == 7'b0000001) dec.md[f3] = 1'b1;
        else if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: dec.alu[ALU_ADD] = 1'b1;
            3'b001: dec.alu[ALU_SLL] = 1'b1;
            3'b010: dec.alu[ALU_SLT] = 1'b1;
            3'b011: begin dec.alu[ALU_SLT] = 1'b1; dec.is_unsigned = 1'b1; end
            3'b100: dec.alu[ALU_XOR] = 1'b1;
            3'b101: dec.alu[ALU_SRL] = 1'b1;
            3'b110: dec.alu[ALU_OR] = 1'b1;
            default: dec.alu[ALU_AND] = 1'b1;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000) dec.alu[ALU_SUB] = 1'b1;
          else if (f3 == 3'b101) dec.alu[ALU_SRA] = 1'b1;
          else bad = 1'b1;
        end else bad = 1'b1;
      end
      OPC_OP32: begin
        dec.src1_is_reg = 1'b1;
        dec.src2_is_reg = 1'b1;
        dec.need_to_wb = 1'b1;
        dec.is_word = 1'b1;
        bad = !RV64;
        if (f7 == 7'b0000001) begin
          if (f3 == 3'b000 || f3[2]) dec.md[f3] = 1'b1;
          else bad = 1'b1;
        end else if (f7 == 7'b0000000) begin
          if (f3 == 3'b000) dec.alu[ALU_ADD] = 1'b1;
          else if (f3 == 3'b001) dec.alu[ALU_SLL] = 1'b1;
          else if (f3 == 3'b101) dec.alu[ALU_SRL] = 1'b1;
          else bad = 1'b1;
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000) dec.alu[ALU_SUB] = 1'b1;
          else if (f3 == 3'b101) dec.alu[ALU_SRA] = 1'b1;
          else bad = 1'b1;
        end else bad = 1'b1;
      end
      OPC_LUI: begin
        dec.imm = sext(imm_u);
        dec.need_to_wb = 1'b1;
        dec.is_imm = 1'b1;
        dec.alu[ALU_LUI] = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm = sext(imm_u);
        dec.need_to_wb = 1'b1;
        dec.is_imm = 1'b1;
        dec.alu[ALU_AUIPC] = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm = sext(imm_b);
        dec.src1_is_reg = 1'b1;
        dec.src2_is_reg = 1'b1;
        case (f3)
          3'b000: dec.cx[CX_BEQ] = 1'b1;
          3'b001: dec.cx[CX_BNE] = 1'b1;
          3'b100: dec.cx[CX_BLT] = 1'b1;
          3'b101: dec.cx[CX_BGE] = 1'b1;
          3'b110: begin dec.cx[CX_BLT] = 1'b1; dec.is_unsigned = 1'b1; end
          3'b111: begin dec.cx[CX_BGE] = 1'b1; dec.is_unsigned = 1'b1; end
          default: bad = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.imm = sext(imm_j);
        dec.need_to_wb = 1'b1;
        dec.cx[CX_JAL] = 1'b1;
      end
      OPC_JALR: begin
        dec.imm = sext(imm_i);
        dec.src1_is_reg = 1'b1;
        dec.need_to_wb = 1'b1;
        dec.cx[CX_JALR] = 1'b1;
        bad = (f3 != 3'b000);
      end
      // SYSTEM and MISC-MEM are not handled yet and fall here with unknown opcodes
      default: bad = 1'b1;
    endcase
    if (dec.rd == 5'd0) dec.need_to_wb = 1'b0;
    if (bad) begin
      dec.illegal     = 1'b1;
      dec.cx          = '0;
      dec.alu         = '0;
      dec.md          = '0;
      dec.need_to_wb  = 1'b0;
      dec.is_load     = 1'b0;
      dec.is_store    = 1'b0;
      dec.is_word     = 1'b0;
      dec.is_unsigned = 1'b0;
      dec.ls_size     = '0;
    end
  end

  uop_t             main_q, skid_q;
  logic             main_v, skid_v, ready_q;
  logic [CNT_W-1:0] count_q;
  logic             accept, handoff, skid_next;

  assign accept    = in_valid && ready_q;
  assign handoff   = main_v && out_ready;
  assign skid_next = main_v && !out_ready && (skid_v || accept);

  // Main/skid buffer: skid only fills while main is stalled, and refills main first
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_q  <= '0;
      skid_q  <= '0;
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      ready_q <= 1'b1;
      count_q <= '0;
    end else if (flush) begin
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      if (out_ready || !main_v) begin
        if (skid_v) begin
          main_q <= skid_q;
          main_v <= 1'b1;
          skid_v <= 1'b0;
        end else begin
          main_v <= accept;
          if (accept) main_q <= dec;
        end
      end else if (accept) begin
        skid_q <= dec;
        skid_v <= 1'b1;
      end
      ready_q <= !skid_next;
      if (handoff) count_q <= count_q + CNT_W'(1);
    end
  end

  assign in_ready        = ready_q;
  assign out_valid       = main_v;
  assign out_pc          = main_q.pc;
  assign out_inst        = main_q.inst;
  assign out_rs1         = main_q.rs1;
  assign out_rs2         = main_q.rs2;
  assign out_rd          = main_q.rd;
  assign out_imm         = main_q.imm;
  assign out_src1_is_reg = main_q.src1_is_reg;
  assign out_src2_is_reg = main_q.src2_is_reg;
  assign out_need_to_wb  = main_q.need_to_wb;
  assign out_cx_type     = main_q.cx;
  assign out_alu_type    = main_q.alu;
  assign out_muldiv_type = main_q.md;
  assign out_is_word     = main_q.is_word;
  assign out_is_imm      = main_q.is_imm;
  assign out_is_load     = main_q.is_load;
  assign out_is_store    = main_q.is_store;
  assign out_is_unsigned = main_q.is_unsigned;
  assign out_ls_size     = main_q.ls_size;
  assign out_illegal     = main_q.illegal;
  assign decode_count    = count_q;

endmodule
